// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one single-port data RAM between the CPU load/store path and the
//   read-only VGA framebuffer fetch path. The arbiter is round-robin, and RAM
//   reads have a fixed latency. Each transaction ends with a one-cycle ack.
//
// Handshake (both requesters):
//   The requester raises *_req and holds its address/data stable until the
//   arbiter grants it. Address, data and we are sampled on the grant edge, so
//   later changes are ignored. The arbiter pulses *_ack for exactly one cycle
//   when the transaction completes. Read data is valid in that cycle and is
//   held afterwards. A req dropped after the grant does not abort the access.
//
// Ports:
//   clock, resetn             rising-edge clock, synchronous active-low reset
//   cpu_req/we/addr/wdata     CPU request (we=1 write, we=0 read)
//   cpu_ack, cpu_rdata        CPU completion pulse and read data
//   vga_req/addr              VGA read request
//   vga_ack, vga_rdata        VGA completion pulse and read data
//   mem_addr/wdata/we         registered RAM controls
//   mem_rdata                 RAM read data, READ_LATENCY cycles after mem_addr
//   busy                      high in any state other than IDLE
//   dbg_state_o               current FSM state (0 IDLE, 1 ACCESS, 2 WAIT, 3 DONE)
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int AW           = 16,
  parameter int DW           = 16,
  parameter int READ_LATENCY = 1
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  input  logic          vga_req,
  input  logic [AW-1:0] vga_addr,
  output logic          vga_ack,
  output logic [DW-1:0] vga_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic [1:0]    dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  // The WAIT state lasts READ_LATENCY cycles, so the counter starts one below.
  localparam logic [1:0] CNT_INIT = 2'(READ_LATENCY - 1);

  state_t          state_q;
  logic [1:0]      cnt_q;
  logic            owner_cpu_q;    // 1: current transaction belongs to the CPU
  logic            we_q;           // latched write flag of current transaction
  logic            last_cpu_q;     // 1: CPU was granted most recently
  logic [AW-1:0]   mem_addr_q;
  logic [DW-1:0]   mem_wdata_q;
  logic            mem_we_q;
  logic            cpu_ack_q;
  logic            vga_ack_q;
  logic [DW-1:0]   cpu_rdata_q;
  logic [DW-1:0]   vga_rdata_q;
  logic            busy_q;

  // Round-robin decision. On a tie the side that was not granted last wins.
  logic grant_cpu;
  logic grant_vga;
  assign grant_cpu = cpu_req & (~vga_req | ~last_cpu_q);
  assign grant_vga = vga_req & (~cpu_req |  last_cpu_q);

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      cnt_q       <= 2'd0;
      owner_cpu_q <= 1'b0;
      we_q        <= 1'b0;
      last_cpu_q  <= 1'b0;      // last grant = VGA, so the CPU wins the first tie
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      cpu_ack_q   <= 1'b0;
      vga_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      vga_rdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      // Pulse outputs default low; the states below raise them for one cycle.
      mem_we_q  <= 1'b0;
      cpu_ack_q <= 1'b0;
      vga_ack_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (grant_cpu) begin
            owner_cpu_q <= 1'b1;
            we_q        <= cpu_we;
            last_cpu_q  <= 1'b1;
            mem_addr_q  <= cpu_addr;
            mem_wdata_q <= cpu_wdata;
            mem_we_q    <= cpu_we;
            busy_q      <= 1'b1;
            state_q     <= S_ACCESS;
          end else if (grant_vga) begin
            // The VGA path never writes, so mem_wdata keeps its old value.
            owner_cpu_q <= 1'b0;
            we_q        <= 1'b0;
            last_cpu_q  <= 1'b0;
            mem_addr_q  <= vga_addr;
            busy_q      <= 1'b1;
            state_q     <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (we_q) begin
            // Only the CPU can write, so the ack goes to the owner.
            cpu_ack_q <= owner_cpu_q;
            vga_ack_q <= ~owner_cpu_q;
            state_q   <= S_DONE;
          end else begin
            cnt_q   <= CNT_INIT;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt_q == 2'd0) begin
            if (owner_cpu_q) begin
              cpu_rdata_q <= mem_rdata;
              cpu_ack_q   <= 1'b1;
            end else begin
              vga_rdata_q <= mem_rdata;
              vga_ack_q   <= 1'b1;
            end
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end
        S_DONE: begin
          // Requests are ignored here. This dead cycle keeps a req that is
          // still high during the ack from being granted a second time.
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_we      = mem_we_q;
  assign cpu_ack     = cpu_ack_q;
  assign vga_ack     = vga_ack_q;
  assign cpu_rdata   = cpu_rdata_q;
  assign vga_rdata   = vga_rdata_q;
  assign busy        = busy_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int RL = 2;

  // ---------------- clock / reset / signals ----------------
  logic          clock = 1'b0;
  logic          resetn;
  logic          cpu_req, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;
  logic          vga_req;
  logic [AW-1:0] vga_addr;
  logic          vga_ack;
  logic [DW-1:0] vga_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic [DW-1:0] mem_rdata;
  logic          busy;
  logic [1:0]    dbg_state;

  always #5 clock = ~clock;

  mem_port_arbiter #(.AW(AW), .DW(DW), .READ_LATENCY(RL)) dut (
    .clock       (clock),
    .resetn      (resetn),
    .cpu_req     (cpu_req),
    .cpu_we      (cpu_we),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_ack     (cpu_ack),
    .cpu_rdata   (cpu_rdata),
    .vga_req     (vga_req),
    .vga_addr    (vga_addr),
    .vga_ack     (vga_ack),
    .vga_rdata   (vga_rdata),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_we      (mem_we),
    .mem_rdata   (mem_rdata),
    .busy        (busy),
    .dbg_state_o (dbg_state)
  );

  // RAM model: 256 words, two-stage read pipeline (READ_LATENCY = 2).
  // Word i is preloaded with 16'h1000 + i.
  logic [DW-1:0] ram [0:255];
  logic [DW-1:0] rd1, rd2;
  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 16'h1000 + 16'(i);
    rd1 = '0;
    rd2 = '0;
  end
  always @(posedge clock) begin
    if (mem_we) ram[mem_addr[7:0]] <= mem_wdata;
    rd1 <= ram[mem_addr[7:0]];
    rd2 <= rd1;
  end
  assign mem_rdata = rd2;

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic rstn, input logic creq, input logic cwe,
                       input logic [AW-1:0] caddr, input logic [DW-1:0] cwd,
                       input logic vreq, input logic [AW-1:0] vaddr);
    resetn    = rstn;
    cpu_req   = creq;
    cpu_we    = cwe;
    cpu_addr  = caddr;
    cpu_wdata = cwd;
    vga_req   = vreq;
    vga_addr  = vaddr;
  endtask

  // Advance one rising edge, then settle so registered outputs are sampled
  // well away from the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic          rstn, creq, cwe;
    logic [AW-1:0] caddr;
    logic [DW-1:0] cwd;
    logic          vreq;
    logic [AW-1:0] vaddr;
    logic          e_cack, e_vack, e_mwe, e_busy;
    logic [AW-1:0] e_maddr;
    logic [DW-1:0] e_crd, e_vrd;
    logic          mwd_chk;
    logic [DW-1:0] e_mwd;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rstn, input logic creq, input logic cwe,
                     input logic [AW-1:0] caddr, input logic [DW-1:0] cwd,
                     input logic vreq, input logic [AW-1:0] vaddr,
                     input logic e_cack, input logic e_vack, input logic e_mwe,
                     input logic e_busy, input logic [AW-1:0] e_maddr,
                     input logic [DW-1:0] e_crd, input logic [DW-1:0] e_vrd,
                     input logic mwd_chk, input logic [DW-1:0] e_mwd);
    vec_t v;
    v.rstn = rstn; v.creq = creq; v.cwe = cwe; v.caddr = caddr; v.cwd = cwd;
    v.vreq = vreq; v.vaddr = vaddr;
    v.e_cack = e_cack; v.e_vack = e_vack; v.e_mwe = e_mwe; v.e_busy = e_busy;
    v.e_maddr = e_maddr; v.e_crd = e_crd; v.e_vrd = e_vrd;
    v.mwd_chk = mwd_chk; v.e_mwd = e_mwd;
    vecs.push_back(v);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : main
    int first_ack;
    int n_ack;
    logic [DW-1:0] rd_at_ack;

    drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0);

    // Each row: inputs applied, one edge, then expected outputs.
    //   rstn creq cwe caddr    cwdata   vreq vaddr   | cack vack mwe busy maddr    crd      vrd      mwdchk mwd
    // Reset held for two cycles
    add(0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000,  0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 1, 16'h0000);
    add(0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000,  0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 1, 16'h0000);
    add(1, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000,  0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 1, 16'h0000);
    // CPU write 0040 <- BEEF: ack in the second cycle after req
    add(1, 1, 1, 16'h0040, 16'hBEEF, 0, 16'h0000,  0, 0, 1, 1, 16'h0040, 16'h0000, 16'h0000, 1, 16'hBEEF);
    add(1, 1, 1, 16'h0040, 16'hBEEF, 0, 16'h0000,  1, 0, 0, 1, 16'h0040, 16'h0000, 16'h0000, 1, 16'hBEEF);
    add(1, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000,  0, 0, 0, 0, 16'h0040, 16'h0000, 16'h0000, 1, 16'hBEEF);
    // CPU read 0040: ack in the fourth cycle after req, rdata BEEF
    add(1, 1, 0, 16'h0040, 16'h0000, 0, 16'h0000,  0, 0, 0, 1, 16'h0040, 16'h0000, 16'h0000, 0, 16'h0000);
    add(1, 1, 0, 16'h0040, 16'h0000, 0, 16'h0000,  0, 0, 0, 1, 16'h0040, 16'h0000, 16'h0000, 0, 16'h0000);
    add(1, 1, 0, 16'h0040, 16'h0000, 0, 16'h0000,  0, 0, 0, 1, 16'h0040, 16'h0000, 16'h0000, 0, 16'h0000);
    add(1, 1, 0, 16'h0040, 16'h0000, 0, 16'h0000,  1, 0, 0, 1, 16'h0040, 16'hBEEF, 16'h0000, 0, 16'h0000);
    add(1, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000,  0, 0, 0, 0, 16'h0040, 16'hBEEF, 16'h0000, 0, 16'h0000);
    // Reset clears rdata and last_grant
    add(0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000,  0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 1, 16'h0000);
    // Tie: CPU first (addr changes after grant are ignored)
    add(1, 1, 0, 16'h0010, 16'h0000, 1, 16'h0020,  0, 0, 0, 1, 16'h0010, 16'h0000, 16'h0000, 0, 16'h0000);
    add(1, 1, 0, 16'h0077, 16'h0000, 1, 16'h0020,  0, 0, 0, 1, 16'h0010, 16'h0000, 16'h0000, 0, 16'h0000);
    add(1, 1, 0, 16'h0077, 16'h0000, 1, 16'h0020,  0, 0, 0, 1, 16'h0010, 16'h0000, 16'h0000, 0, 16'h0000);
    add(1, 1, 0, 16'h0077, 16'h0000, 1, 16'h0020,  1, 0, 0, 1, 16'h0010, 16'h1010, 16'h0000, 0, 16'h0000);
    // Dead cycle, then VGA granted
    add(1, 1, 0, 16'h0077, 16'h0000, 1, 16'h0020,  0, 0, 0, 0, 16'h0010, 16'h1010, 16'h0000, 0, 16'h0000);
    add(1, 1, 0, 16'h0077, 16'h0000, 1, 16'h0020,  0, 0, 0, 1, 16'h0020, 16'h1010, 16'h0000, 0, 16'h0000);
    add(1, 1, 0, 16'h0077, 16'h0000, 1, 16'h0020,  0, 0, 0, 1, 16'h0020, 16'h1010, 16'h0000, 0, 16'h0000);
    add(1, 1, 0, 16'h0077, 16'h0000, 1, 16'h0020,  0, 0, 0, 1, 16'h0020, 16'h1010, 16'h0000, 0, 16'h0000);
    add(1, 1, 0, 16'h0077, 16'h0000, 1, 16'h0020,  0, 1, 0, 1, 16'h0020, 16'h1010, 16'h1020, 0, 16'h0000);
    add(1, 1, 0, 16'h0030, 16'h0000, 1, 16'h0050,  0, 0, 0, 0, 16'h0020, 16'h1010, 16'h1020, 0, 16'h0000);
    // Both still high: CPU again, then VGA again
    add(1, 1, 0, 16'h0030, 16'h0000, 1, 16'h0050,  0, 0, 0, 1, 16'h0030, 16'h1010, 16'h1020, 0, 16'h0000);
    add(1, 1, 0, 16'h0030, 16'h0000, 1, 16'h0050,  0, 0, 0, 1, 16'h0030, 16'h1010, 16'h1020, 0, 16'h0000);
    add(1, 1, 0, 16'h0030, 16'h0000, 1, 16'h0050,  0, 0, 0, 1, 16'h0030, 16'h1010, 16'h1020, 0, 16'h0000);
    add(1, 1, 0, 16'h0030, 16'h0000, 1, 16'h0050,  1, 0, 0, 1, 16'h0030, 16'h1030, 16'h1020, 0, 16'h0000);
    add(1, 1, 0, 16'h0030, 16'h0000, 1, 16'h0050,  0, 0, 0, 0, 16'h0030, 16'h1030, 16'h1020, 0, 16'h0000);
    add(1, 1, 0, 16'h0030, 16'h0000, 1, 16'h0050,  0, 0, 0, 1, 16'h0050, 16'h1030, 16'h1020, 0, 16'h0000);
    add(1, 1, 0, 16'h0030, 16'h0000, 1, 16'h0050,  0, 0, 0, 1, 16'h0050, 16'h1030, 16'h1020, 0, 16'h0000);
    add(1, 1, 0, 16'h0030, 16'h0000, 1, 16'h0050,  0, 0, 0, 1, 16'h0050, 16'h1030, 16'h1020, 0, 16'h0000);
    add(1, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000,  0, 1, 0, 1, 16'h0050, 16'h1030, 16'h1050, 0, 16'h0000);
    add(1, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000,  0, 0, 0, 0, 16'h0050, 16'h1030, 16'h1050, 0, 16'h0000);

    foreach (vecs[i]) begin
      drive(vecs[i].rstn, vecs[i].creq, vecs[i].cwe, vecs[i].caddr, vecs[i].cwd,
            vecs[i].vreq, vecs[i].vaddr);
      tick();
      check($sformatf("v%0d cpu_ack", i),   32'(cpu_ack),   32'(vecs[i].e_cack));
      check($sformatf("v%0d vga_ack", i),   32'(vga_ack),   32'(vecs[i].e_vack));
      check($sformatf("v%0d mem_we", i),    32'(mem_we),    32'(vecs[i].e_mwe));
      check($sformatf("v%0d busy", i),      32'(busy),      32'(vecs[i].e_busy));
      check($sformatf("v%0d mem_addr", i),  32'(mem_addr),  32'(vecs[i].e_maddr));
      check($sformatf("v%0d cpu_rdata", i), 32'(cpu_rdata), 32'(vecs[i].e_crd));
      check($sformatf("v%0d vga_rdata", i), 32'(vga_rdata), 32'(vecs[i].e_vrd));
      if (vecs[i].mwd_chk)
        check($sformatf("v%0d mem_wdata", i), 32'(mem_wdata), 32'(vecs[i].e_mwd));
    end

    // ---- Reset in the middle of a read: no ack ever follows ----
    drive(1'b1, 1'b1, 1'b0, 16'h0060, 16'h0000, 1'b0, 16'h0000);
    tick();
    check("midread state ACCESS", 32'(dbg_state), 32'd1);
    tick();
    check("midread state WAIT", 32'(dbg_state), 32'd2);
    drive(1'b0, 1'b1, 1'b0, 16'h0060, 16'h0000, 1'b0, 16'h0000);
    tick();
    check("midread rst state", 32'(dbg_state), 32'd0);
    check("midread rst busy",  32'(busy),      32'd0);
    check("midread rst mem_we", 32'(mem_we),   32'd0);
    check("midread rst addr",  32'(mem_addr),  32'd0);
    drive(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000);
    n_ack = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (cpu_ack || vga_ack) n_ack++;
    end
    check("midread ack count", 32'(n_ack), 32'd0);
    check("midread busy after", 32'(busy), 32'd0);

    // ---- Reset right after a write grant: mem_we cut off ----
    drive(1'b1, 1'b1, 1'b1, 16'h0070, 16'h1234, 1'b0, 16'h0000);
    tick();
    check("midwrite mem_we", 32'(mem_we), 32'd1);
    drive(1'b0, 1'b1, 1'b1, 16'h0070, 16'h1234, 1'b0, 16'h0000);
    tick();
    check("midwrite rst mem_we", 32'(mem_we), 32'd0);
    check("midwrite rst state", 32'(dbg_state), 32'd0);
    drive(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000);
    n_ack = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (cpu_ack || vga_ack || mem_we) n_ack++;
    end
    check("midwrite no ack/we", 32'(n_ack), 32'd0);

    // ---- VGA req high for one cycle only: read still completes once ----
    drive(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0005);
    first_ack = 0;
    n_ack = 0;
    rd_at_ack = '0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (c == 1) drive(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000);
      if (vga_ack) begin
        n_ack++;
        if (first_ack == 0) begin
          first_ack = c;
          rd_at_ack = vga_rdata;
        end
      end
    end
    check("drop ack latency", 32'(first_ack), 32'(RL + 2));
    check("drop ack count",   32'(n_ack),     32'd1);
    check("drop rdata",       32'(rd_at_ack), 32'h1005);
    check("drop busy after",  32'(busy),      32'd0);
    check("drop rdata held",  32'(vga_rdata), 32'h1005);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
